// File: rtl/fixed_square.sv
// Sequential shift-and-add squarer: 8.4 unsigned operand in, exact 16.8 square out,
// zero-extended to OUT_W bits. One partial product per clock, IN_W clocks per result.
module fixed_square #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [IN_W-1:0]  in_data,
   output logic             busy,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data
);

   localparam int ACC_W = 2 * IN_W;
   localparam int CNT_W = $clog2(IN_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t           state;
   logic [IN_W-1:0]  op;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic [ACC_W-1:0] addend;
   logic [ACC_W-1:0] acc_next;

   // NOTE: every signal written in always_comb gets a default first so no latch can be inferred.
   always_comb begin
      addend   = {{IN_W{1'b0}}, op} << cnt;
      acc_next = acc;
      if (op[cnt]) begin
         acc_next = acc + addend;
      end
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op        <= '0;
         acc       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!en) begin
         // Synchronous clear: same effect as reset, and it wins over start.
         state     <= IDLE;
         op        <= '0;
         acc       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  op    <= in_data;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  out_data  <= OUT_W'(acc_next);
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_square.sv
// Self-checking bench for fixed_square: directed corner cases plus random operands,
// all checked against an arithmetic reference (op*op, fixed latency, integer sqrt).
module tb_fixed_square;

   localparam int IN_W  = 12;
   localparam int OUT_W = 32;
   localparam int LAT   = IN_W;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             start;
   logic [IN_W-1:0]  in_data;
   logic             busy;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;

   int total = 0;
   int bad   = 0;

   fixed_square #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .start     (start),
      .in_data   (in_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a request; returns just after the accepting edge E0.
   task automatic start_op(input logic [IN_W-1:0] op);
      start   = 1'b1;
      in_data = op;
      tick();
      start   = 1'b0;
      in_data = ~op;
   endtask

   // Edges elapsed until out_valid is seen, bounded.
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_valids(input int cycles, output int cnt, output logic [31:0] last);
      cnt  = 0;
      last = '0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (out_valid) begin
            cnt++;
            last = out_data;
         end
      end
   endtask

   function automatic logic [31:0] isqrt(input logic [31:0] v);
      logic [31:0] r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   task automatic run_op(input string tag, input logic [IN_W-1:0] op);
      int n;
      logic [31:0] exp;
      exp = 32'(op) * 32'(op);
      start_op(op);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_valid(n);
      check({tag, "_lat"}, n, LAT);
      check({tag, "_data"}, out_data, exp);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_pulse"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int n;
      int vcnt;
      logic [31:0] last;
      logic [IN_W-1:0] r_op;

      rst = 1'b1; en = 1'b1; start = 1'b0; in_data = '0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      run_op("one", 12'h010);
      run_op("zero", 12'h000);
      run_op("two5", 12'h028);
      run_op("op5a8", 12'h5A8);
      run_op("max", 12'hFFF);
      check("max_top_byte", 32'(out_data[31:24]), 32'd0);

      // Back-to-back: second start issued in the out_valid cycle.
      start_op(12'h0FF);
      wait_valid(n);
      check("b2b_first", out_data, 32'h0000FE01);
      start = 1'b1; in_data = 12'h123;
      tick();
      start = 1'b0;
      check("b2b_gap_valid", 32'(out_valid), 32'd0);
      wait_valid(n);
      check("b2b_spacing", n + 1, LAT + 1);
      check("b2b_second", out_data, 32'h00014AC9);
      tick();

      // start during CALC is ignored.
      start_op(12'h003);
      tick(); tick(); tick();
      start = 1'b1; in_data = 12'hFFF;
      tick();
      start = 1'b0;
      count_valids(30, vcnt, last);
      check("ignore_cnt", vcnt, 1);
      check("ignore_data", last, 32'h00000009);

      // Async reset mid-CALC.
      start_op(12'h0AB);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_data", out_data, 32'd0);
      check("midrst_valid", 32'(out_valid), 32'd0);
      tick();
      rst = 1'b0;
      count_valids(16, vcnt, last);
      check("midrst_novalid", vcnt, 0);
      run_op("after_rst", 12'h002);

      // en low for one edge mid-CALC, with a start that must be ignored.
      start_op(12'h050);
      repeat (3) tick();
      en = 1'b0; start = 1'b1; in_data = 12'h077;
      tick();
      check("en_busy", 32'(busy), 32'd0);
      check("en_data", out_data, 32'd0);
      check("en_valid", 32'(out_valid), 32'd0);
      en = 1'b1; start = 1'b0;
      count_valids(20, vcnt, last);
      check("en_novalid", vcnt, 0);
      check("en_idle", 32'(busy), 32'd0);

      // Loop-back through a square-root reference.
      run_op("loop", 12'h3C4);
      check("loop_sqrt", isqrt(out_data), 32'h3C4);

      for (int i = 0; i < 20; i++) begin
         r_op = IN_W'($urandom_range(0, (1 << IN_W) - 1));
         run_op($sformatf("rand%0d", i), r_op);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
